// File: rtl/llc_bus_responder_pkg.sv
// Shared LLC bus definitions: operation codes, snoop results, data source and responder states.
// snoop_from_addr turns a line offset into the modelled snoop outcome of the other caches.
package LLC_defs;

    typedef enum logic [2:0] {
        NOBUSOP    = 3'd0,
        READ       = 3'd1,
        WRITE      = 3'd2,
        INVALIDATE = 3'd3,
        RWIM       = 3'd4
    } busOperation;

    typedef enum logic [1:0] {
        NOHIT    = 2'd0,
        HIT      = 2'd1,
        HITM     = 2'd2,
        NORESULT = 2'd3
    } snoopResults;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_PEER = 2'd2
    } dataSource;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SNOOP = 2'd1,
        ST_MEM   = 2'd2,
        ST_RESP  = 2'd3
    } respState;

    function automatic snoopResults snoop_from_addr(input logic [1:0] offset);
        case (offset)
            2'b00:   return HIT;
            2'b01:   return HITM;
            default: return NOHIT;
        endcase
    endfunction

endpackage

// File: rtl/llc_bus_latency.sv
// Loadable down-counter used to time memory accesses; done flags the final cycle (count of 1).
module llc_bus_latency #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (load)
            r_count <= load_val;
        else if (dec && (r_count != '0))
            r_count <= r_count - 1'b1;
    end

    assign value = r_count;
    assign done  = (r_count == W'(1));

endmodule

// File: rtl/llc_bus_responder.sv
// Far-end responder of the LLC shared bus: snoops, models memory latency, returns a completion
// and keeps bus-traffic statistics.
module llc_bus_responder
    import LLC_defs::*;
#(
    parameter int MEM_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  busOperation      req_op,
    input  logic [31:0]      req_addr,
    output logic             resp_valid,
    input  logic             resp_ready,
    output busOperation      resp_op,
    output snoopResults      resp_snoop,
    output dataSource        resp_src,
    output logic             busy,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] mem_reads,
    output logic [CNT_W-1:0] mem_writes,
    output logic [CNT_W-1:0] peer_xfers,
    output logic [CNT_W-1:0] invalidates
);

    respState          r_state, w_next;
    busOperation       r_op, r_resp_op;
    snoopResults       r_resp_snoop, w_snoop;
    dataSource         r_resp_src;
    logic [1:0]        r_offset;
    logic [CNT_W-1:0]  r_mem_reads, r_mem_writes, r_peer_xfers, r_invalidates;
    logic              w_lat_load, w_lat_dec, w_lat_done;
    logic [7:0]        w_lat_value;
    logic              w_is_rd, w_mem_path, w_peer_path, w_accept;
    logic              w_unused;

    assign w_unused    = ^{req_addr[31:2], w_lat_value};
    assign w_accept    = (r_state == ST_IDLE) && req_valid;
    assign w_snoop     = snoop_from_addr(r_offset);
    assign w_is_rd     = (r_op == READ) || (r_op == RWIM);
    assign w_peer_path = w_is_rd && (w_snoop == HITM);
    assign w_mem_path  = (r_op == WRITE) || (w_is_rd && (w_snoop != HITM));

    llc_bus_latency #(.W(8)) u_latency (
        .clk      (clk),
        .rst      (rst),
        .load     (w_lat_load),
        .dec      (w_lat_dec),
        .load_val (8'(MEM_LAT)),
        .value    (w_lat_value),
        .done     (w_lat_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_lat_load = 1'b0;
        w_lat_dec  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // NOBUSOP is handshaken but dropped without leaving IDLE
                if (req_valid && (req_op != NOBUSOP))
                    w_next = ST_SNOOP;
            end
            ST_SNOOP: begin
                if (w_mem_path) begin
                    w_next     = ST_MEM;
                    w_lat_load = 1'b1;
                end else begin
                    w_next = ST_RESP;
                end
            end
            ST_MEM: begin
                w_lat_dec = 1'b1;
                if (w_lat_done)
                    w_next = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op         <= NOBUSOP;
            r_offset     <= 2'b00;
            r_resp_op    <= NOBUSOP;
            r_resp_snoop <= NORESULT;
            r_resp_src   <= SRC_NONE;
        end else begin
            if (w_accept) begin
                r_op     <= req_op;
                r_offset <= req_addr[1:0];
            end
            // response fields change only here, so they hold between completions
            if (r_state == ST_SNOOP) begin
                r_resp_op    <= r_op;
                r_resp_snoop <= (r_op == WRITE) ? NORESULT : w_snoop;
                r_resp_src   <= w_mem_path ? SRC_MEM : (w_peer_path ? SRC_PEER : SRC_NONE);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_reads   <= '0;
            r_mem_writes  <= '0;
            r_peer_xfers  <= '0;
            r_invalidates <= '0;
        end else if (clr_stats) begin
            r_mem_reads   <= '0;
            r_mem_writes  <= '0;
            r_peer_xfers  <= '0;
            r_invalidates <= '0;
        end else begin
            if ((r_state == ST_MEM) && w_lat_done && w_is_rd)
                r_mem_reads <= r_mem_reads + 1'b1;
            if ((r_state == ST_MEM) && w_lat_done && (r_op == WRITE))
                r_mem_writes <= r_mem_writes + 1'b1;
            if ((r_state == ST_SNOOP) && w_peer_path)
                r_peer_xfers <= r_peer_xfers + 1'b1;
            if ((r_state == ST_SNOOP) && (r_op == INVALIDATE))
                r_invalidates <= r_invalidates + 1'b1;
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign resp_valid  = (r_state == ST_RESP);
    assign resp_op     = r_resp_op;
    assign resp_snoop  = r_resp_snoop;
    assign resp_src    = r_resp_src;
    assign mem_reads   = r_mem_reads;
    assign mem_writes  = r_mem_writes;
    assign peer_xfers  = r_peer_xfers;
    assign invalidates = r_invalidates;

endmodule

// File: tb/tb_llc_bus_responder.sv
// Scoreboard bench for llc_bus_responder: directed scenarios followed by random traffic,
// with a monitor checking each completion against a behavioural model of the bus rules.
module tb_llc_bus_responder;
    import LLC_defs::*;

    localparam int MEM_LAT = 4;
    localparam int CNT_W   = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    busOperation      req_op = NOBUSOP;
    logic [31:0]      req_addr = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    busOperation      resp_op;
    snoopResults      resp_snoop;
    dataSource        resp_src;
    logic             busy;
    logic             clr_stats = 1'b0;
    logic [CNT_W-1:0] mem_reads, mem_writes, peer_xfers, invalidates;

    llc_bus_responder #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_op     (resp_op),
        .resp_snoop  (resp_snoop),
        .resp_src    (resp_src),
        .busy        (busy),
        .clr_stats   (clr_stats),
        .mem_reads   (mem_reads),
        .mem_writes  (mem_writes),
        .peer_xfers  (peer_xfers),
        .invalidates (invalidates)
    );

    always #5 clk = ~clk;

    typedef struct {
        busOperation op;
        snoopResults sn;
        dataSource   src;
        int          exp_cyc;
        bit          clr;
    } item_t;

    item_t sb[$];
    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;
    int    m_rd = 0, m_wr = 0, m_peer = 0, m_inv = 0;
    int    ready_mode = 0;   // 0 random, 1 held low, 2 held high

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference rules: WRITE never snoops and always goes to memory; HITM on a read is
    // served by the peer cache; INVALIDATE never moves data.
    task automatic model(input busOperation op, input logic [31:0] addr,
                         output snoopResults sn, output dataSource src, output int lat);
        int off;
        off = int'(addr % 4);
        if (op == WRITE) begin
            sn = NORESULT; src = SRC_MEM; lat = 2 + MEM_LAT;
        end else begin
            sn = (off == 0) ? HIT : ((off == 1) ? HITM : NOHIT);
            if (op == INVALIDATE) begin
                src = SRC_NONE; lat = 2;
            end else if (sn == HITM) begin
                src = SRC_PEER; lat = 2;
            end else begin
                src = SRC_MEM; lat = 2 + MEM_LAT;
            end
        end
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_mem_reads"},   mem_reads,   m_rd);
        chk({tag, "_mem_writes"},  mem_writes,  m_wr);
        chk({tag, "_peer_xfers"},  peer_xfers,  m_peer);
        chk({tag, "_invalidates"}, invalidates, m_inv);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        resp_ready = (ready_mode == 0) ? ($urandom_range(0, 3) != 0) : (ready_mode == 2);
    end

    // Monitor: pops the expected completion when resp_valid rises, then checks hold-steady.
    initial begin
        item_t       it;
        bit          active;
        busOperation h_op;
        snoopResults h_sn;
        dataSource   h_src;
        active = 1'b0;
        h_op = NOBUSOP; h_sn = NORESULT; h_src = SRC_NONE;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
            end else if (resp_valid) begin
                chk("req_ready_low_in_resp", req_ready, 0);
                chk("busy_in_resp", busy, 1);
                if (!active) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_resp", 1, 0);
                    end else begin
                        it = sb.pop_front();
                        chk("resp_op", resp_op, it.op);
                        chk("resp_snoop", resp_snoop, it.sn);
                        chk("resp_src", resp_src, it.src);
                        chk("resp_latency_cycle", cyc, it.exp_cyc);
                        if (it.clr) begin
                            m_rd = 0; m_wr = 0; m_peer = 0; m_inv = 0;
                        end else if (it.op == WRITE) begin
                            m_wr++;
                        end else if (it.op == INVALIDATE) begin
                            m_inv++;
                        end else if (it.src == SRC_PEER) begin
                            m_peer++;
                        end else begin
                            m_rd++;
                        end
                        chk_counts("resp");
                    end
                    active = 1'b1;
                    h_op = resp_op; h_sn = resp_snoop; h_src = resp_src;
                end else begin
                    chk("hold_op", resp_op, h_op);
                    chk("hold_snoop", resp_snoop, h_sn);
                    chk("hold_src", resp_src, h_src);
                end
                if (resp_ready)
                    active = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(posedge clk); #1;
        while ((busy || resp_valid) && (n < 300)) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy || resp_valid)
            chk("wait_idle_timeout", 1, 0);
    endtask

    // Presents one request starting in an idle cycle; returns one cycle after acceptance.
    task automatic send(input busOperation op, input logic [31:0] addr, input bit clr_flag);
        item_t it;
        int    lat;
        wait_idle();
        model(op, addr, it.sn, it.src, lat);
        it.op      = op;
        it.exp_cyc = cyc + lat;
        it.clr     = clr_flag;
        if (op != NOBUSOP)
            sb.push_back(it);
        req_valid = 1'b1; req_op = op; req_addr = addr;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = NOBUSOP;
    endtask

    initial begin
        int n;
        busOperation op;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp_op", resp_op, NOBUSOP);
        chk("rst_resp_snoop", resp_snoop, NORESULT);
        chk("rst_resp_src", resp_src, SRC_NONE);
        chk_counts("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        ready_mode = 2;

        send(READ, 32'h0000_1000, 1'b0);
        send(RWIM, 32'h0000_2001, 1'b0);
        send(WRITE, 32'h0000_3003, 1'b0);

        // stalled completion: fields and req_ready must hold while resp_ready is low
        wait_idle();
        ready_mode = 1;
        send(INVALIDATE, 32'h0000_4002, 1'b0);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stall_resp_seen", resp_valid, 1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid_held", resp_valid, 1);
        end
        ready_mode = 2;
        wait_idle();
        chk_counts("after_inval");

        // NOBUSOP is accepted and dropped
        req_valid = 1'b1; req_op = NOBUSOP; req_addr = 32'h0000_5000;
        repeat (4) begin
            @(negedge clk);
            chk("nobusop_req_ready", req_ready, 1);
            chk("nobusop_busy", busy, 0);
            chk("nobusop_resp_valid", resp_valid, 0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk_counts("nobusop");

        // reset during the second MEM cycle discards the request
        send(READ, 32'h0000_6000, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_resp_valid", resp_valid, 0);
        sb.delete();
        m_rd = 0; m_wr = 0; m_peer = 0; m_inv = 0;
        chk_counts("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_busy", busy, 0);
        chk("postrst_resp_valid", resp_valid, 0);
        send(READ, 32'h0000_7000, 1'b0);
        wait_idle();
        chk_counts("postrst_read");

        // clr_stats coincides with the mem_reads increment; the clear wins
        send(READ, 32'h0000_8000, 1'b1);
        repeat (MEM_LAT) @(posedge clk);
        #1;
        clr_stats = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
        wait_idle();
        chk_counts("clr_collide");

        ready_mode = 0;
        for (int i = 0; i < 40; i++) begin
            op = busOperation'(3'($urandom_range(0, 4)));
            send(op, $urandom, 1'b0);
        end
        wait_idle();
        chk("scoreboard_empty", sb.size(), 0);
        chk_counts("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/llc_bus_responder.md
Name: llc_bus_responder

Overview:
- Responder at the far end of the LLC's shared-bus interface.
- Accepts one bus operation at a time (READ, WRITE, INVALIDATE, RWIM) from the LLC and drives a snoop result on behalf of the other caches.
- Models memory access latency for line fills and write-backs, then returns a completion response.
- Keeps bus-traffic statistics that are reported alongside the LLC hit/miss counts.

Parameters:
- MEM_LAT, 4: memory access cycles for a fill or write-back; legal range 1..255.
- CNT_W, 32: width of each statistics counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  a bus operation is presented.
- req_ready  out  1  responder can accept a request.
- req_op  in  busOperation  bus operation code.
- req_addr  in  32  line address; bits [1:0] select the modelled snoop outcome.
- resp_valid  out  1  completion is available.
- resp_ready  in  1  LLC consumes the completion.
- resp_op  out  busOperation  echo of the accepted operation.
- resp_snoop  out  snoopResults  snoop result for the operation.
- resp_src  out  dataSource  where the data came from: SRC_NONE, SRC_MEM or SRC_PEER.
- busy  out  1  high in any state other than IDLE.
- clr_stats  in  1  synchronous clear of all counters.
- mem_reads, mem_writes, peer_xfers, invalidates  out  CNT_W  statistics counters.

Behaviour:
Reset:
- rst high moves the FSM to IDLE immediately, whatever state it was in; an in-flight request is discarded with no response.
- While in reset: req_ready=1, resp_valid=0, resp_op=NOBUSOP, resp_snoop=NORESULT, resp_src=SRC_NONE, busy=0, all counters 0, latency counter 0.

FSM states: IDLE, SNOOP, MEM, RESP.

IDLE:
- req_ready=1.
- The handshake is req_valid && req_ready. On it, capture req_op and req_addr.
- A NOBUSOP request is accepted, then dropped: the FSM stays in IDLE and no counter changes.
- Any other operation moves the FSM to SNOOP.

SNOOP (exactly 1 cycle). Register the snoop result:
- READ, RWIM, INVALIDATE use addr[1:0]: 00 gives HIT, 01 gives HITM, 10 or 11 gives NOHIT.
- WRITE gives NORESULT.

SNOOP next state:
- READ or RWIM with HITM: RESP, src=SRC_PEER, peer_xfers+1. This is a cache-to-cache intervention with no memory access.
- READ or RWIM otherwise: MEM, src=SRC_MEM, load the latency counter with MEM_LAT.
- WRITE: MEM, src=SRC_MEM, load the latency counter with MEM_LAT.
- INVALIDATE: RESP, src=SRC_NONE, invalidates+1.

MEM:
- Decrement the latency counter every cycle.
- When the counter reaches 1, go to RESP. Increment mem_reads for READ or RWIM, mem_writes for WRITE.

RESP:
- resp_valid=1. resp_op, resp_snoop and resp_src hold steady until resp_ready is high.
- On resp_valid && resp_ready, return to IDLE. resp_valid drops the next cycle.
- A new request cannot be accepted in that same cycle; req_ready=0 outside IDLE.

Latency, with acceptance at cycle N:
- resp_valid first high at N+2 for peer and invalidate cases.
- resp_valid first high at N+2+MEM_LAT for memory cases.
- Minimum back-to-back request spacing is 3 cycles.

Counters:
- Counters wrap modulo 2^CNT_W.
- When clr_stats is asserted in the same cycle as an increment, the clear wins and the result is 0.
- clr_stats does not affect the FSM.

Outputs between responses:
- Response fields hold their last values; only resp_valid qualifies them.

Decomposition:
- LLC_defs package: reuse busOperation and snoopResults.
- LLC_defs package: add the dataSource enum and a respState enum for the FSM.
- LLC_defs package: add a function snoop_from_addr (2-bit offset in, snoopResults out) shared with any bench model.
- Sub-module llc_bus_latency: a loadable down-counter with load, value and done (done when the count is 1). It is reused later for memory-timing variants.

Test Plan:
- READ to addr 0x0000_1000 (offset 00), MEM_LAT=4, accepted at cycle 10 → resp at cycle 16 with HIT, SRC_MEM; mem_reads=1.
- RWIM to addr 0x0000_2001 (offset 01) → resp at N+2 with HITM, SRC_PEER; peer_xfers=1; mem_reads unchanged.
- WRITE to addr 0x0000_3003 → NORESULT, SRC_MEM, resp at N+6; mem_writes=1.
- INVALIDATE to addr 0x0000_4002, with resp_ready held low for 5 cycles → NOHIT, SRC_NONE; resp_valid and fields stable for all 5 cycles; req_ready=0 throughout; invalidates=1.
- NOBUSOP with req_valid=1 → no state change, no response, counters unchanged, req_ready stays 1.
- rst pulsed in the 2nd MEM cycle of a READ → next cycle IDLE, resp_valid=0, all counters 0; a new READ afterwards completes normally.
- Increment coinciding with clr_stats (READ completing as clr_stats=1) → mem_reads=0.
